// File: rtl/mii_frame_receiver.sv
// mii_frame_receiver: MII byte stream -> validated payload stream with sof/eof markers and frame statistics.
// Latency: payload byte on rx_data in cycle N appears on out_data in cycle N+2; status pulse two cycles after the last byte.
// Backpressure: none; the MII link cannot be stalled, so the consumer must accept every out_valid beat.
module mii_frame_receiver #(
  parameter int unsigned PREAMBLE_CYCLES = 7,
  parameter int unsigned MIN_DATA_CYCLES = 46,
  parameter int unsigned MAX_DATA_CYCLES = 1500,
  parameter logic [7:0]  PREAMBLE_CODE   = 8'h55,
  parameter logic [7:0]  SFD_CODE        = 8'hD5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_ctrl,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic        frame_ok,
  output logic        frame_err,
  output logic        err_preamble,
  output logic        err_short,
  output logic        err_long,
  output logic [15:0] byte_count,
  output logic [15:0] frame_count,
  output logic [15:0] err_count
);

  // Preamble counter saturates one above the required count, so it needs
  // room for PREAMBLE_CYCLES+1.
  localparam int PW = $clog2(PREAMBLE_CYCLES + 2);

  localparam logic [PW-1:0] PRE_ONE    = PW'(1);
  localparam logic [PW-1:0] PRE_TARGET = PW'(PREAMBLE_CYCLES);
  localparam logic [PW-1:0] PRE_SAT    = PW'(PREAMBLE_CYCLES + 1);
  localparam logic [15:0]   MIN_BC     = 16'(MIN_DATA_CYCLES);
  localparam logic [15:0]   MAX_BC     = 16'(MAX_DATA_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } state_t;

  state_t state;
  state_t state_nxt;

  // Preamble tracking and the one-byte payload hold register. Holding one
  // byte back is what lets the last byte carry out_eof in the same cycle
  // the link drops rx_ctrl.
  logic [PW-1:0] pre_cnt;
  logic [PW-1:0] pre_cnt_nxt;
  logic [7:0]    hold_data;
  logic [7:0]    hold_data_nxt;
  logic          hold_vld;
  logic          hold_vld_nxt;
  logic          hold_first;
  logic          hold_first_nxt;
  logic [15:0]   byte_count_nxt;

  // Next values of the registered outputs.
  logic [7:0]    out_data_nxt;
  logic          out_valid_nxt;
  logic          out_sof_nxt;
  logic          out_eof_nxt;
  logic          frame_ok_nxt;
  logic          frame_err_nxt;
  logic          err_preamble_nxt;
  logic          err_short_nxt;
  logic          err_long_nxt;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, hold-register and output decode.
  always_comb begin
    state_nxt        = state;
    pre_cnt_nxt      = pre_cnt;
    hold_data_nxt    = hold_data;
    hold_vld_nxt     = hold_vld;
    hold_first_nxt   = hold_first;
    byte_count_nxt   = byte_count;
    out_data_nxt     = out_data;
    out_valid_nxt    = 1'b0;
    out_sof_nxt      = 1'b0;
    out_eof_nxt      = 1'b0;
    frame_ok_nxt     = 1'b0;
    frame_err_nxt    = 1'b0;
    err_preamble_nxt = 1'b0;
    err_short_nxt    = 1'b0;
    err_long_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (rx_ctrl) begin
          if (rx_data == PREAMBLE_CODE) begin
            state_nxt   = PREAMBLE;
            pre_cnt_nxt = PRE_ONE;
          end else begin
            // Covers a bare SFD and joining a frame already in flight.
            state_nxt        = DROP;
            frame_err_nxt    = 1'b1;
            err_preamble_nxt = 1'b1;
          end
        end
      end

      PREAMBLE: begin
        if (!rx_ctrl) begin
          state_nxt        = IDLE;
          frame_err_nxt    = 1'b1;
          err_preamble_nxt = 1'b1;
        end else if (rx_data == PREAMBLE_CODE) begin
          if (pre_cnt != PRE_SAT) begin
            pre_cnt_nxt = pre_cnt + PRE_ONE;
          end
        end else if ((rx_data == SFD_CODE) && (pre_cnt == PRE_TARGET)) begin
          state_nxt      = DATA;
          byte_count_nxt = '0;
          hold_vld_nxt   = 1'b0;
          hold_first_nxt = 1'b1;
        end else begin
          state_nxt        = DROP;
          frame_err_nxt    = 1'b1;
          err_preamble_nxt = 1'b1;
        end
      end

      DATA: begin
        if (!rx_ctrl) begin
          // End of frame: flush the held byte as the last beat and report.
          state_nxt     = IDLE;
          out_valid_nxt = hold_vld;
          out_sof_nxt   = hold_vld & hold_first;
          out_eof_nxt   = hold_vld;
          if (hold_vld) begin
            out_data_nxt = hold_data;
          end
          hold_vld_nxt = 1'b0;
          if (byte_count >= MIN_BC) begin
            frame_ok_nxt = 1'b1;
          end else begin
            frame_err_nxt = 1'b1;
            err_short_nxt = 1'b1;
          end
        end else if (byte_count == MAX_BC) begin
          // One byte too many: close the stream on the held byte, drop the rest.
          state_nxt     = DROP;
          out_valid_nxt = hold_vld;
          out_sof_nxt   = hold_vld & hold_first;
          out_eof_nxt   = hold_vld;
          if (hold_vld) begin
            out_data_nxt = hold_data;
          end
          hold_vld_nxt  = 1'b0;
          frame_err_nxt = 1'b1;
          err_long_nxt  = 1'b1;
        end else begin
          if (hold_vld) begin
            out_valid_nxt  = 1'b1;
            out_sof_nxt    = hold_first;
            out_data_nxt   = hold_data;
            hold_first_nxt = 1'b0;
          end
          hold_data_nxt  = rx_data;
          hold_vld_nxt   = 1'b1;
          byte_count_nxt = byte_count + 16'd1;
        end
      end

      DROP: begin
        if (!rx_ctrl) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_cnt      <= '0;
      hold_data    <= '0;
      hold_vld     <= 1'b0;
      hold_first   <= 1'b0;
      byte_count   <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_sof      <= 1'b0;
      out_eof      <= 1'b0;
      frame_ok     <= 1'b0;
      frame_err    <= 1'b0;
      err_preamble <= 1'b0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
    end else begin
      pre_cnt      <= pre_cnt_nxt;
      hold_data    <= hold_data_nxt;
      hold_vld     <= hold_vld_nxt;
      hold_first   <= hold_first_nxt;
      byte_count   <= byte_count_nxt;
      out_data     <= out_data_nxt;
      out_valid    <= out_valid_nxt;
      out_sof      <= out_sof_nxt;
      out_eof      <= out_eof_nxt;
      frame_ok     <= frame_ok_nxt;
      frame_err    <= frame_err_nxt;
      err_preamble <= err_preamble_nxt;
      err_short    <= err_short_nxt;
      err_long     <= err_long_nxt;
    end
  end

  // Good/rejected frame counters, free-running with natural 16-bit wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      if (frame_ok_nxt) begin
        frame_count <= frame_count + 16'd1;
      end
      if (frame_err_nxt) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mii_frame_receiver.sv
// Bench for mii_frame_receiver: table of whole-frame vectors plus hand-written
// sequences for latency, back-to-back frames and reset in the middle of a frame.
module tb_mii_frame_receiver;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_ctrl;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_sof;
  logic        out_eof;
  logic        frame_ok;
  logic        frame_err;
  logic        err_preamble;
  logic        err_short;
  logic        err_long;
  logic [15:0] byte_count;
  logic [15:0] frame_count;
  logic [15:0] err_count;

  mii_frame_receiver dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_ctrl      (rx_ctrl),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_sof      (out_sof),
    .out_eof      (out_eof),
    .frame_ok     (frame_ok),
    .frame_err    (frame_err),
    .err_preamble (err_preamble),
    .err_short    (err_short),
    .err_long     (err_long),
    .byte_count   (byte_count),
    .frame_count  (frame_count),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: cumulative counts; payload byte k of a frame must be k mod 256.
  int         m_valid = 0;
  int         m_sof = 0;
  int         m_eof = 0;
  int         m_ok = 0;
  int         m_err = 0;
  int         m_ep = 0;
  int         m_es = 0;
  int         m_el = 0;
  int         m_bad = 0;
  int         m_idx = 0;
  int         m_sof_cyc = 0;
  int         m_stat_cyc = 0;
  logic [7:0] m_eof_data = 8'h00;

  always @(negedge clk) begin
    m_bad <= m_bad
           + ((out_valid && (out_data != (out_sof ? 8'd0 : m_idx[7:0]))) ? 1 : 0)
           + (((out_sof || out_eof) && !out_valid) ? 1 : 0)
           + (((err_preamble || err_short || err_long) && !frame_err) ? 1 : 0)
           + ((frame_ok && frame_err) ? 1 : 0);
    if (out_valid) begin
      m_valid <= m_valid + 1;
      m_idx   <= out_sof ? 1 : m_idx + 1;
      if (out_sof) begin
        m_sof     <= m_sof + 1;
        m_sof_cyc <= cyc;
      end
      if (out_eof) begin
        m_eof      <= m_eof + 1;
        m_eof_data <= out_data;
      end
    end
    if (frame_ok) m_ok <= m_ok + 1;
    if (frame_err) m_err <= m_err + 1;
    if (frame_ok || frame_err) m_stat_cyc <= cyc;
    if (err_preamble) m_ep <= m_ep + 1;
    if (err_short) m_es <= m_es + 1;
    if (err_long) m_el <= m_el + 1;
  end

  int checks = 0;
  int failures = 0;
  int s_valid, s_sof, s_eof, s_ok, s_err, s_ep, s_es, s_el, s_bad;
  int first_cyc = 0;
  int last_cyc = 0;
  int exp_fc = 0;
  int exp_ec = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic take_snap();
    s_valid = m_valid; s_sof = m_sof; s_eof = m_eof; s_ok = m_ok; s_err = m_err;
    s_ep = m_ep; s_es = m_es; s_el = m_el; s_bad = m_bad;
  endtask

  task automatic send_byte(input logic c, input logic [7:0] d);
    @(posedge clk);
    #1;
    rx_ctrl = c;
    rx_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_byte(1'b0, 8'h00);
  endtask

  // len < 0: preamble only, then idle (link drops mid-preamble).
  task automatic send_frame(input int npre, input logic [7:0] sfd, input int len);
    for (int i = 0; i < npre; i++) send_byte(1'b1, 8'h55);
    if (len >= 0) begin
      send_byte(1'b1, sfd);
      for (int i = 0; i < len; i++) begin
        send_byte(1'b1, 8'(i));
        if (i == 0) first_cyc = cyc;
        last_cyc = cyc;
      end
    end
    send_byte(1'b0, 8'h00);
  endtask

  typedef struct {
    int         npre;
    logic [7:0] sfd;
    int         len;
    int         ev;
    int         esof;
    int         eeof;
    int         eok;
    int         eerr;
    int         eep;
    int         ees;
    int         eel;
    int         ebc;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  initial begin
    //          npre sfd    len   valid sof eof ok err ep es el  bc
    vecs[0]  = '{7, 8'hD5,   46,   46,  1,  1,  1, 0,  0, 0, 0,   46};
    vecs[1]  = '{7, 8'hD5,   10,   10,  1,  1,  0, 1,  0, 1, 0,   10};
    vecs[2]  = '{5, 8'hD5,   46,    0,  0,  0,  0, 1,  1, 0, 0,   -1};
    vecs[3]  = '{7, 8'hD5, 1501, 1500,  1,  1,  0, 1,  0, 0, 1, 1500};
    vecs[4]  = '{7, 8'hD5,   45,   45,  1,  1,  0, 1,  0, 1, 0,   45};
    vecs[5]  = '{7, 8'hD5, 1500, 1500,  1,  1,  1, 0,  0, 0, 0, 1500};
    vecs[6]  = '{7, 8'hD5,    0,    0,  0,  0,  0, 1,  0, 1, 0,    0};
    vecs[7]  = '{7, 8'hD5,    1,    1,  1,  1,  0, 1,  0, 1, 0,    1};
    vecs[8]  = '{8, 8'hD5,   46,    0,  0,  0,  0, 1,  1, 0, 0,   -1};
    vecs[9]  = '{0, 8'hD5,   46,    0,  0,  0,  0, 1,  1, 0, 0,   -1};
    vecs[10] = '{7, 8'hAA,   46,    0,  0,  0,  0, 1,  1, 0, 0,   -1};
    vecs[11] = '{3, 8'hD5,   -1,    0,  0,  0,  0, 1,  1, 0, 0,   -1};

    reset   = 1'b0;
    rx_ctrl = 1'b0;
    rx_data = 8'h00;
    idle(3);

    // Reset state.
    @(negedge clk);
    chk("rst out_data", int'(out_data), 0);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst out_sof", int'(out_sof), 0);
    chk("rst out_eof", int'(out_eof), 0);
    chk("rst frame_ok", int'(frame_ok), 0);
    chk("rst frame_err", int'(frame_err), 0);
    chk("rst err_flags", int'({err_preamble, err_short, err_long}), 0);
    chk("rst byte_count", int'(byte_count), 0);
    chk("rst frame_count", int'(frame_count), 0);
    chk("rst err_count", int'(err_count), 0);

    reset = 1'b1;
    idle(2);

    // First good frame: also checks input-to-output latency.
    take_snap();
    send_frame(7, 8'hD5, 46);
    idle(4);
    exp_fc++;
    chk("lat sof", m_sof_cyc - first_cyc, 2);
    chk("lat status", m_stat_cyc - last_cyc, 2);
    chk("lat valid", m_valid - s_valid, 46);
    chk("lat eof_data", int'(m_eof_data), 45);
    chk("lat frame_count", int'(frame_count), exp_fc);

    // Table-driven frames.
    for (int i = 0; i < NV; i++) begin
      take_snap();
      send_frame(vecs[i].npre, vecs[i].sfd, vecs[i].len);
      idle(4);
      exp_fc += vecs[i].eok;
      exp_ec += vecs[i].eerr;
      chk($sformatf("v%0d valid", i), m_valid - s_valid, vecs[i].ev);
      chk($sformatf("v%0d sof", i), m_sof - s_sof, vecs[i].esof);
      chk($sformatf("v%0d eof", i), m_eof - s_eof, vecs[i].eeof);
      chk($sformatf("v%0d frame_ok", i), m_ok - s_ok, vecs[i].eok);
      chk($sformatf("v%0d frame_err", i), m_err - s_err, vecs[i].eerr);
      chk($sformatf("v%0d err_preamble", i), m_ep - s_ep, vecs[i].eep);
      chk($sformatf("v%0d err_short", i), m_es - s_es, vecs[i].ees);
      chk($sformatf("v%0d err_long", i), m_el - s_el, vecs[i].eel);
      chk($sformatf("v%0d data_protocol", i), m_bad - s_bad, 0);
      chk($sformatf("v%0d frame_count", i), int'(frame_count), exp_fc);
      chk($sformatf("v%0d err_count", i), int'(err_count), exp_ec);
      if (vecs[i].ebc >= 0)
        chk($sformatf("v%0d byte_count", i), int'(byte_count), vecs[i].ebc);
      if (vecs[i].eeof > 0)
        chk($sformatf("v%0d eof_data", i), int'(m_eof_data), (vecs[i].ev - 1) % 256);
    end

    // Back-to-back 64-byte frames separated by a single idle cycle.
    take_snap();
    send_frame(7, 8'hD5, 64);
    send_frame(7, 8'hD5, 64);
    idle(4);
    exp_fc += 2;
    chk("b2b valid", m_valid - s_valid, 128);
    chk("b2b sof", m_sof - s_sof, 2);
    chk("b2b eof", m_eof - s_eof, 2);
    chk("b2b frame_ok", m_ok - s_ok, 2);
    chk("b2b frame_err", m_err - s_err, 0);
    chk("b2b data_protocol", m_bad - s_bad, 0);
    chk("b2b frame_count", int'(frame_count), exp_fc);
    chk("b2b byte_count", int'(byte_count), 64);

    // Reset asserted at payload byte 20, released while the frame continues.
    for (int i = 0; i < 7; i++) send_byte(1'b1, 8'h55);
    send_byte(1'b1, 8'hD5);
    for (int i = 0; i < 20; i++) send_byte(1'b1, 8'(i));
    send_byte(1'b1, 8'd20);
    reset = 1'b0;
    send_byte(1'b1, 8'd21);
    @(negedge clk);
    chk("midrst out_valid", int'(out_valid), 0);
    chk("midrst out_data", int'(out_data), 0);
    chk("midrst byte_count", int'(byte_count), 0);
    chk("midrst frame_count", int'(frame_count), 0);
    chk("midrst err_count", int'(err_count), 0);
    take_snap();
    send_byte(1'b1, 8'd22);
    reset = 1'b1;
    for (int i = 23; i < 30; i++) send_byte(1'b1, 8'(i));
    send_byte(1'b0, 8'h00);
    idle(4);
    exp_fc = 0;
    exp_ec = 1;
    chk("midrst valid", m_valid - s_valid, 0);
    chk("midrst eof", m_eof - s_eof, 0);
    chk("midrst frame_ok", m_ok - s_ok, 0);
    chk("midrst frame_err", m_err - s_err, 1);
    chk("midrst err_preamble", m_ep - s_ep, 1);
    chk("midrst err_count after", int'(err_count), exp_ec);

    take_snap();
    send_frame(7, 8'hD5, 46);
    idle(4);
    exp_fc++;
    chk("post frame_ok", m_ok - s_ok, 1);
    chk("post valid", m_valid - s_valid, 46);
    chk("post data_protocol", m_bad - s_bad, 0);
    chk("post frame_count", int'(frame_count), exp_fc);
    chk("post err_count", int'(err_count), exp_ec);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout actual=%0d required=0", cyc);
    $fatal(1);
  end

endmodule
